// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin fetch/data front end sequencing a single-port mem.
// Fetch reads and data reads/writes share the pins; one access in flight at a time.
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req_valid,
  output logic          i_req_ready,
  input  logic [AW-1:0] i_addr,
  output logic          i_resp_valid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req_valid,
  output logic          d_req_ready,
  input  logic          d_req_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_resp_valid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_out
);
  typedef enum logic {IDLE, ACCESS} state_t;
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_last_d;
  logic          r_src_d;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_i_resp;
  logic          r_d_resp;
  logic [DW-1:0] r_i_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          w_idle;
  logic          w_gnt_d;
  logic          w_done;
  // readies are forced low while reset is held so nothing is offered mid-reset
  assign w_idle       = rst_n && r_state == IDLE;
  assign w_gnt_d      = d_req_valid && (!i_req_valid || !r_last_d);
  assign i_req_ready  = w_idle && i_req_valid && !w_gnt_d;
  assign d_req_ready  = w_idle && w_gnt_d;
  assign w_done       = r_state == ACCESS && r_cnt == 4'd0;
  assign mem_rd       = r_state == ACCESS && !r_we;
  assign mem_wr       = w_done && r_we;
  assign mem_addr     = r_addr;
  assign mem_data     = r_data;
  assign i_resp_valid = r_i_resp;
  assign d_resp_valid = r_d_resp;
  assign i_rdata      = r_i_rdata;
  assign d_rdata      = r_d_rdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_last_d  <= 1'b0;
      r_src_d   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_i_resp  <= 1'b0;
      r_d_resp  <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_i_resp <= 1'b0;
      r_d_resp <= 1'b0;
      if (i_req_ready || d_req_ready) begin
        r_state  <= ACCESS;
        r_cnt    <= WS;
        r_src_d  <= d_req_ready;
        r_last_d <= d_req_ready;
        r_we     <= d_req_ready && d_req_we;
        r_addr   <= d_req_ready ? d_addr : i_addr;
        r_data   <= d_req_ready ? d_wdata : r_data;
      end else if (r_state == ACCESS) begin
        if (r_cnt != 4'd0) begin
          r_cnt <= r_cnt - 4'd1;
        end else begin
          r_state  <= IDLE;
          r_i_resp <= !r_src_d;
          r_d_resp <= r_src_d;
          if (!r_we && r_src_d) r_d_rdata <= mem_out;
          if (!r_we && !r_src_d) r_i_rdata <= mem_out;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter with zero and three wait states.
module tb_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  logic        rst_n0, iv0, dv0, dwe0, irdy0, drdy0, iresp0, dresp0, mrd0, mwr0;
  logic [15:0] ia0, da0, ma0;
  logic [31:0] dwd0, ird0, drd0, md0, mout0;
  logic        rst_n3, iv3, dv3, dwe3, irdy3, drdy3, iresp3, dresp3, mrd3, mwr3;
  logic [15:0] ia3, da3, ma3;
  logic [31:0] dwd3, ird3, drd3, md3, mout3;
  logic [31:0] mem0 [256];
  logic [31:0] mem3 [256];
  logic        pl0, pl3;
  logic [7:0]  pla;
  logic [31:0] pld;
  mem_arbiter #(.AW(16), .DW(32), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n0), .i_req_valid(iv0), .i_req_ready(irdy0), .i_addr(ia0),
    .i_resp_valid(iresp0), .i_rdata(ird0), .d_req_valid(dv0), .d_req_ready(drdy0),
    .d_req_we(dwe0), .d_addr(da0), .d_wdata(dwd0), .d_resp_valid(dresp0), .d_rdata(drd0),
    .mem_addr(ma0), .mem_data(md0), .mem_rd(mrd0), .mem_wr(mwr0), .mem_out(mout0));
  mem_arbiter #(.AW(16), .DW(32), .WAIT_STATES(3)) u3 (
    .clk(clk), .rst_n(rst_n3), .i_req_valid(iv3), .i_req_ready(irdy3), .i_addr(ia3),
    .i_resp_valid(iresp3), .i_rdata(ird3), .d_req_valid(dv3), .d_req_ready(drdy3),
    .d_req_we(dwe3), .d_addr(da3), .d_wdata(dwd3), .d_resp_valid(dresp3), .d_rdata(drd3),
    .mem_addr(ma3), .mem_data(md3), .mem_rd(mrd3), .mem_wr(mwr3), .mem_out(mout3));
  always @(posedge clk) begin
    if (mwr0) mem0[ma0[7:0]] <= md0;
    else if (pl0) mem0[pla] <= pld;
    if (mwr3) mem3[ma3[7:0]] <= md3;
    else if (pl3) mem3[pla] <= pld;
  end
  assign mout0 = mrd0 ? mem0[ma0[7:0]] : '0;
  assign mout3 = mrd3 ? mem3[ma3[7:0]] : '0;

  task automatic preload0(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk); pl0 = 1'b1; pla = a; pld = d;
    @(negedge clk); pl0 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n0 = 1'b0; rst_n3 = 1'b0; iv0 = 1'b1; dv3 = 1'b1;
    @(negedge clk); #1;
    tests++;
    if ({irdy0, drdy0, iresp0, dresp0, mrd0, mwr0, ird0, drd0, ma0, md0} !== '0) begin
      fails++; $display("FAIL reset_w0 got rdy=%b%b resp=%b%b rd/wr=%b%b rdata=%h/%h addr=%h data=%h exp all 0",
        irdy0, drdy0, iresp0, dresp0, mrd0, mwr0, ird0, drd0, ma0, md0);
    end
    tests++;
    if ({irdy3, drdy3, iresp3, dresp3, mrd3, mwr3, ird3, drd3, ma3, md3} !== '0) begin
      fails++; $display("FAIL reset_w3 got rdy=%b%b resp=%b%b rd/wr=%b%b rdata=%h/%h addr=%h data=%h exp all 0",
        irdy3, drdy3, iresp3, dresp3, mrd3, mwr3, ird3, drd3, ma3, md3);
    end
    iv0 = 1'b0; dv3 = 1'b0;
    @(negedge clk); rst_n0 = 1'b1; rst_n3 = 1'b1;
  endtask

  task automatic test_fetch_read;
    preload0(8'd15, 32'd123);
    @(negedge clk); iv0 = 1'b1; ia0 = 16'd15; #1;
    tests++;
    if ({irdy0, drdy0} !== 2'b10) begin
      fails++; $display("FAIL fetch_accept got rdy i/d=%b%b exp 10", irdy0, drdy0);
    end
    @(negedge clk); iv0 = 1'b0; #1;
    tests++;
    if ({mrd0, mwr0, ma0, iresp0, irdy0} !== {1'b1, 1'b0, 16'd15, 1'b0, 1'b0}) begin
      fails++; $display("FAIL fetch_access got rd=%b wr=%b addr=%0d resp=%b rdy=%b exp rd=1 wr=0 addr=15 resp=0 rdy=0",
        mrd0, mwr0, ma0, iresp0, irdy0);
    end
    @(negedge clk); #1;
    tests++;
    if ({iresp0, dresp0, mrd0, ird0} !== {1'b1, 1'b0, 1'b0, 32'd123}) begin
      fails++; $display("FAIL fetch_resp got iresp=%b dresp=%b rd=%b rdata=%0d exp 1 0 0 123", iresp0, dresp0, mrd0, ird0);
    end
    @(negedge clk); #1;
    tests++;
    if (iresp0 !== 1'b0) begin
      fails++; $display("FAIL fetch_pulse_width got iresp=%b exp 0", iresp0);
    end
  endtask

  task automatic test_write_read;
    @(negedge clk); dv0 = 1'b1; dwe0 = 1'b1; da0 = 16'd16; dwd0 = 32'd223; #1;
    tests++;
    if ({drdy0, irdy0} !== 2'b10) begin
      fails++; $display("FAIL wr_accept got rdy d/i=%b%b exp 10", drdy0, irdy0);
    end
    @(negedge clk); dv0 = 1'b0; #1;
    tests++;
    if ({mwr0, mrd0, ma0, md0} !== {1'b1, 1'b0, 16'd16, 32'd223}) begin
      fails++; $display("FAIL wr_pins got wr=%b rd=%b addr=%0d data=%0d exp 1 0 16 223", mwr0, mrd0, ma0, md0);
    end
    @(negedge clk); dv0 = 1'b1; dwe0 = 1'b0; da0 = 16'd16; #1;
    tests++;
    if ({dresp0, mwr0, drdy0, drd0, mem0[16]} !== {1'b1, 1'b0, 1'b1, 32'd0, 32'd223}) begin
      fails++; $display("FAIL wr_ack got dresp=%b wr=%b drdy=%b drdata=%0d mem16=%0d exp 1 0 1 0 223",
        dresp0, mwr0, drdy0, drd0, mem0[16]);
    end
    @(negedge clk); dv0 = 1'b0; #1;
    tests++;
    if ({mrd0, mwr0, ma0} !== {1'b1, 1'b0, 16'd16}) begin
      fails++; $display("FAIL rd_pins got rd=%b wr=%b addr=%0d exp 1 0 16", mrd0, mwr0, ma0);
    end
    @(negedge clk); #1;
    tests++;
    if ({dresp0, iresp0, drd0, ird0} !== {1'b1, 1'b0, 32'd223, 32'd123}) begin
      fails++; $display("FAIL rd_resp got dresp=%b iresp=%b drdata=%0d irdata=%0d exp 1 0 223 123", dresp0, iresp0, drd0, ird0);
    end
  endtask

  task automatic test_contention;
    logic [8:0] e_drdy, e_irdy, e_dresp, e_iresp;
    e_drdy = 9'b100010001; e_irdy = 9'b001000100;
    e_dresp = 9'b001000100; e_iresp = 9'b100010000;
    preload0(8'd1, 32'h1111_0001);
    preload0(8'd2, 32'h2222_0002);
    rst_n0 = 1'b0;
    @(negedge clk); rst_n0 = 1'b1;
    iv0 = 1'b1; ia0 = 16'd1; dv0 = 1'b1; dwe0 = 1'b0; da0 = 16'd2;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      tests++;
      if ({drdy0, irdy0, dresp0, iresp0} !== {e_drdy[c], e_irdy[c], e_dresp[c], e_iresp[c]}) begin
        fails++; $display("FAIL contention_c%0d got drdy/irdy/dresp/iresp=%b%b%b%b exp %b%b%b%b", c,
          drdy0, irdy0, dresp0, iresp0, e_drdy[c], e_irdy[c], e_dresp[c], e_iresp[c]);
      end
      if (c == 2) begin
        tests++;
        if (drd0 !== 32'h2222_0002) begin
          fails++; $display("FAIL contention_drdata got %h exp 22220002", drd0);
        end
      end
      if (c == 4) begin
        tests++;
        if (ird0 !== 32'h1111_0001) begin
          fails++; $display("FAIL contention_irdata got %h exp 11110001", ird0);
        end
      end
    end
    @(negedge clk); iv0 = 1'b0; dv0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ws3_write;
    logic [3:0] mw, mr, rs;
    @(negedge clk); dv3 = 1'b1; dwe3 = 1'b1; da3 = 16'd7; dwd3 = 32'hDEAD_BEEF; #1;
    tests++;
    if (drdy3 !== 1'b1) begin
      fails++; $display("FAIL ws3_wr_accept got drdy=%b exp 1", drdy3);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); dv3 = 1'b0; #1;
      mw[c] = mwr3; mr[c] = mrd3; rs[c] = dresp3;
    end
    tests++;
    if ({mw, mr, rs, ma3, md3} !== {4'b1000, 4'b0000, 4'b0000, 16'd7, 32'hDEAD_BEEF}) begin
      fails++; $display("FAIL ws3_wr_pins got wr=%b rd=%b resp=%b addr=%0d data=%h exp 1000 0000 0000 7 deadbeef",
        mw, mr, rs, ma3, md3);
    end
    @(negedge clk); #1;
    tests++;
    if ({dresp3, mwr3, mem3[7]} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      fails++; $display("FAIL ws3_wr_ack got dresp=%b wr=%b mem7=%h exp 1 0 deadbeef", dresp3, mwr3, mem3[7]);
    end
  endtask

  task automatic test_ws3_read;
    logic [3:0] mw, mr, rs;
    @(negedge clk); dv3 = 1'b1; dwe3 = 1'b0; da3 = 16'd7; #1;
    tests++;
    if (drdy3 !== 1'b1) begin
      fails++; $display("FAIL ws3_rd_accept got drdy=%b exp 1", drdy3);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); dv3 = 1'b0; #1;
      mw[c] = mwr3; mr[c] = mrd3; rs[c] = dresp3;
    end
    tests++;
    if ({mw, mr, rs} !== {4'b0000, 4'b1111, 4'b0000}) begin
      fails++; $display("FAIL ws3_rd_pins got wr=%b rd=%b resp=%b exp 0000 1111 0000", mw, mr, rs);
    end
    @(negedge clk); #1;
    tests++;
    if ({dresp3, mrd3, drd3} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      fails++; $display("FAIL ws3_rd_resp got dresp=%b rd=%b rdata=%h exp 1 0 deadbeef", dresp3, mrd3, drd3);
    end
  endtask

  task automatic test_reset_mid;
    logic seen;
    @(negedge clk); dv3 = 1'b1; dwe3 = 1'b1; da3 = 16'd9; dwd3 = 32'h1111_1111;
    @(negedge clk); dv3 = 1'b0;
    repeat (4) @(negedge clk);
    dv3 = 1'b1; dwe3 = 1'b1; da3 = 16'd9; dwd3 = 32'h55;
    @(negedge clk); dv3 = 1'b0;
    @(negedge clk); rst_n3 = 1'b0; #1;
    tests++;
    if ({irdy3, drdy3, iresp3, dresp3, mrd3, mwr3, ird3, drd3, ma3, md3} !== '0) begin
      fails++; $display("FAIL midreset_outputs got rdy=%b%b resp=%b%b rd/wr=%b%b rdata=%h/%h addr=%h data=%h exp all 0",
        irdy3, drdy3, iresp3, dresp3, mrd3, mwr3, ird3, drd3, ma3, md3);
    end
    @(negedge clk); rst_n3 = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      seen = seen | dresp3 | mwr3;
    end
    tests++;
    if ({seen, mem3[9]} !== {1'b0, 32'h1111_1111}) begin
      fails++; $display("FAIL midreset_abort got resp_or_wr=%b mem9=%h exp 0 11111111", seen, mem3[9]);
    end
    @(negedge clk); dv3 = 1'b1; dwe3 = 1'b0; da3 = 16'd9;
    @(negedge clk); dv3 = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    tests++;
    if ({dresp3, drd3} !== {1'b1, 32'h1111_1111}) begin
      fails++; $display("FAIL midreset_readback got dresp=%b rdata=%h exp 1 11111111", dresp3, drd3);
    end
  endtask

  initial begin
    {iv0, dv0, dwe0, iv3, dv3, dwe3, pl0, pl3} = '0;
    {ia0, da0, ia3, da3} = '0;
    {dwd0, dwd3, pld} = '0;
    pla = '0;
    rst_n0 = 1'b0; rst_n3 = 1'b0;
    test_reset;
    test_fetch_read;
    test_write_read;
    test_contention;
    test_ws3_write;
    test_ws3_read;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
